// File: rtl/bp_be_pkg.sv
// Shared types for the back-end stride prefetch detector.
package bp_be_pkg;

   typedef enum logic [7:0] {
      e_bp_default_cfg = 8'd0
   } bp_params_e;

   typedef enum logic [1:0] {
      e_rpt_init      = 2'd0,
      e_rpt_transient = 2'd1,
      e_rpt_steady    = 2'd2,
      e_rpt_nopred    = 2'd3
   } bp_be_rpt_state_e;

   // Virtual address width implied by a configuration.
   function automatic int unsigned bp_vaddr_width(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 39;
         default:          return 39;
      endcase
   endfunction

endpackage

// File: rtl/bp_be_defines.sv
// Entry-struct declaration macros for the stride detector's reference-prediction table.
`ifndef BP_BE_DEFINES_SVH
`define BP_BE_DEFINES_SVH

`define BP_BE_RPT_ENTRY_WIDTH(vaddr_w, tag_w, stride_w) \
   (1 + (tag_w) + (vaddr_w) + (stride_w) + $bits(bp_be_pkg::bp_be_rpt_state_e))

`define BP_BE_RPT_ENTRY_DECLARE(vaddr_w, tag_w, stride_w) \
   typedef struct packed { \
      logic                          v; \
      logic [(tag_w)-1:0]            tag; \
      logic [(vaddr_w)-1:0]          last_addr; \
      logic [(stride_w)-1:0]         stride; \
      bp_be_pkg::bp_be_rpt_state_e   state; \
   } bp_be_rpt_entry_s

`endif

// File: rtl/bp_be_rpt_update.sv
// Next-entry and prefetch-trigger computation for one RPT lookup.
`ifndef BP_BE_DEFINES_SVH
`include "bp_be_defines.sv"
`endif

module bp_be_rpt_update
   import bp_be_pkg::*;
 #(parameter int unsigned vaddr_width_p  = 39
   , parameter int unsigned tag_width_p  = 10
   , parameter int unsigned stride_width_p = 8
   , localparam int unsigned entry_width_lp =
        `BP_BE_RPT_ENTRY_WIDTH(vaddr_width_p, tag_width_p, stride_width_p))
  (input  logic                      v
   , input  logic [entry_width_lp-1:0] entry
   , input  logic [tag_width_p-1:0]    tag
   , input  logic [vaddr_width_p-1:0]  eff_addr
   , output logic [entry_width_lp-1:0] next_entry_c
   , output logic                      trigger_c
   );

   `BP_BE_RPT_ENTRY_DECLARE(vaddr_width_p, tag_width_p, stride_width_p);

   localparam logic [vaddr_width_p-1:0] stride_max_lp =
      vaddr_width_p'({stride_width_p{1'b1}});

   bp_be_rpt_entry_s          cur, nxt;
   logic                      hit, match;
   logic [vaddr_width_p-1:0]  delta, stride_ext;
   logic [stride_width_p-1:0] delta_trunc;

   assign cur          = bp_be_rpt_entry_s'(entry);
   assign next_entry_c = nxt;

   always_comb begin
      nxt         = cur;
      trigger_c   = 1'b0;
      hit         = v & cur.v & (cur.tag == tag);
      delta       = eff_addr - cur.last_addr;
      delta_trunc = delta[stride_width_p-1:0];
      stride_ext  = vaddr_width_p'(cur.stride);
      // Zero and wrapped (negative) deltas can never equal a nonzero zero-extended stride.
      match       = (delta == stride_ext) && (delta != '0) && (delta <= stride_max_lp);

      if (!hit) begin
         nxt.v         = 1'b1;
         nxt.tag       = tag;
         nxt.last_addr = eff_addr;
         nxt.stride    = '0;
         nxt.state     = e_rpt_init;
      end else begin
         nxt.last_addr = eff_addr;
         case (cur.state)
            e_rpt_init: begin
               if (match) nxt.state = e_rpt_steady;
               else begin
                  nxt.state  = e_rpt_transient;
                  nxt.stride = delta_trunc;
               end
            end
            e_rpt_transient: begin
               if (match) nxt.state = e_rpt_steady;
               else begin
                  nxt.state  = e_rpt_nopred;
                  nxt.stride = delta_trunc;
               end
            end
            e_rpt_steady: begin
               if (match) nxt.state = e_rpt_steady;
               else       nxt.state = e_rpt_init;
            end
            default: begin
               if (match) nxt.state = e_rpt_transient;
               else begin
                  nxt.state  = e_rpt_nopred;
                  nxt.stride = delta_trunc;
               end
            end
         endcase
      end

      trigger_c = hit & match & (nxt.state == e_rpt_steady);
   end

endmodule

// File: rtl/bp_be_stride_detector.sv
// Reference-prediction-table stride detector issuing prefetch requests over valid/ready.
`ifndef BP_BE_DEFINES_SVH
`include "bp_be_defines.sv"
`endif

module bp_be_stride_detector
   import bp_be_pkg::*;
 #(parameter bp_params_e bp_params_p      = e_bp_default_cfg
   , parameter int unsigned rpt_entries_p   = 16
   , parameter int unsigned tag_width_p     = 10
   , parameter int unsigned stride_width_p  = 8
   , parameter int unsigned loop_range_p    = 8
   , parameter int unsigned prefetch_degree_p = 4
   , localparam int unsigned vaddr_width_p  = bp_vaddr_width(bp_params_p))
  (input  logic                      clk_i
   , input  logic                      reset_i
   , input  logic                      flush_i
   , input  logic                      v_i
   , input  logic [vaddr_width_p-1:0]  pc_i
   , input  logic [vaddr_width_p-1:0]  eff_addr_i
   , output logic                      v_o
   , input  logic                      ready_and_i
   , output logic [vaddr_width_p-1:0]  pc_o
   , output logic [vaddr_width_p-1:0]  eff_addr_o
   , output logic [stride_width_p-1:0] stride_o
   , output logic [loop_range_p-1:0]   loop_counter_o
   );

   localparam int unsigned idx_width_lp   = $clog2(rpt_entries_p);
   localparam int unsigned entry_width_lp =
      `BP_BE_RPT_ENTRY_WIDTH(vaddr_width_p, tag_width_p, stride_width_p);

   `BP_BE_RPT_ENTRY_DECLARE(vaddr_width_p, tag_width_p, stride_width_p);

   logic [idx_width_lp-1:0]   idx;
   logic [tag_width_p-1:0]    tag;
   logic [rpt_entries_p-1:0]  valid_q;
   bp_be_rpt_entry_s          payload_q [rpt_entries_p];
   bp_be_rpt_entry_s          rd_entry, wr_entry;
   logic [entry_width_lp-1:0] next_entry;
   logic                      trigger, load;

   assign idx = pc_i[2 +: idx_width_lp];
   assign tag = pc_i[2 + idx_width_lp +: tag_width_p];

   // Valid bits live apart from the payload so only they need reset/flush.
   always_comb begin
      rd_entry   = payload_q[idx];
      rd_entry.v = valid_q[idx];
   end

   bp_be_rpt_update
    #(.vaddr_width_p(vaddr_width_p)
      ,.tag_width_p(tag_width_p)
      ,.stride_width_p(stride_width_p))
    update
     (.v(v_i)
      ,.entry(rd_entry)
      ,.tag(tag)
      ,.eff_addr(eff_addr_i)
      ,.next_entry_c(next_entry)
      ,.trigger_c(trigger)
      );

   assign wr_entry = bp_be_rpt_entry_s'(next_entry);

   always_ff @(posedge clk_i) begin
      if (reset_i)      valid_q <= '0;
      else if (flush_i) valid_q <= '0;
      else if (v_i)     valid_q[idx] <= 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (v_i) payload_q[idx] <= wr_entry;
   end

   // Output register accepts a trigger when empty or draining this cycle; otherwise it is dropped.
   assign load = trigger & (~v_o | ready_and_i);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v_o            <= 1'b0;
         pc_o           <= '0;
         eff_addr_o     <= '0;
         stride_o       <= '0;
         loop_counter_o <= '0;
      end else if (load) begin
         v_o            <= 1'b1;
         pc_o           <= pc_i;
         eff_addr_o     <= eff_addr_i;
         stride_o       <= rd_entry.stride;
         loop_counter_o <= loop_range_p'(prefetch_degree_p);
      end else if (ready_and_i) begin
         v_o            <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Scoreboard bench for the stride detector: directed load streams, monitor on the request port.
module tb_bp_be_stride_detector;
   import bp_be_pkg::*;

   localparam int unsigned vw = bp_vaddr_width(e_bp_default_cfg);
   localparam int unsigned sw = 8;
   localparam int unsigned lw = 8;

   logic          clk = 1'b0;
   logic          reset_i, flush_i, v_i, ready_and_i;
   logic [vw-1:0] pc_i, eff_addr_i;
   logic          v_o;
   logic [vw-1:0] pc_o, eff_addr_o;
   logic [sw-1:0] stride_o;
   logic [lw-1:0] loop_counter_o;

   always #5 clk = ~clk;

   bp_be_stride_detector dut
     (.clk_i(clk)
      ,.reset_i(reset_i)
      ,.flush_i(flush_i)
      ,.v_i(v_i)
      ,.pc_i(pc_i)
      ,.eff_addr_i(eff_addr_i)
      ,.v_o(v_o)
      ,.ready_and_i(ready_and_i)
      ,.pc_o(pc_o)
      ,.eff_addr_o(eff_addr_o)
      ,.stride_o(stride_o)
      ,.loop_counter_o(loop_counter_o)
      );

   typedef struct packed {
      logic [vw-1:0] pc;
      logic [vw-1:0] addr;
      logic [sw-1:0] stride;
      logic [lw-1:0] cnt;
   } req_t;

   req_t sb_q[$];
   req_t got;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every visible request must match the oldest expected one; pop on handshake.
   always @(negedge clk) begin
      if (!reset_i && v_o) begin
         got = {pc_o, eff_addr_o, stride_o, loop_counter_o};
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_req: got pc=%h addr=%h stride=%h cnt=%h, expected no request",
                     pc_o, eff_addr_o, stride_o, loop_counter_o);
         end else begin
            if (got !== sb_q[0]) begin
               n_bad++;
               $display("FAIL req_payload: got pc=%h addr=%h stride=%h cnt=%h, expected pc=%h addr=%h stride=%h cnt=%h",
                        pc_o, eff_addr_o, stride_o, loop_counter_o,
                        sb_q[0].pc, sb_q[0].addr, sb_q[0].stride, sb_q[0].cnt);
            end
            if (ready_and_i) void'(sb_q.pop_front());
         end
      end
   end

   task automatic expect_req(input logic [vw-1:0] pc, input logic [vw-1:0] a, input logic [sw-1:0] s);
      sb_q.push_back({pc, a, s, lw'(4)});
   endtask

   task automatic load(input logic [vw-1:0] pc, input logic [vw-1:0] a);
      @(posedge clk); #1;
      v_i = 1'b1; flush_i = 1'b0; pc_i = pc; eff_addr_i = a;
   endtask

   task automatic flush_load(input logic [vw-1:0] pc, input logic [vw-1:0] a);
      @(posedge clk); #1;
      v_i = 1'b1; flush_i = 1'b1; pc_i = pc; eff_addr_i = a;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         v_i = 1'b0; flush_i = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [vw-1:0] pc_a = vw'(64'h8000_1000);
   localparam logic [vw-1:0] pc_b = vw'(64'h8000_1004);
   localparam logic [vw-1:0] pc_c = vw'(64'h8000_1008);
   localparam logic [vw-1:0] pc_d = vw'(64'h8000_100C);
   localparam logic [vw-1:0] pc_e = vw'(64'h8000_104C);
   localparam logic [vw-1:0] pc_f = vw'(64'h8000_1010);
   localparam logic [vw-1:0] pc_g = vw'(64'h8000_1014);
   localparam logic [vw-1:0] pc_h = vw'(64'h8000_1018);

   initial begin
      reset_i = 1'b1; flush_i = 1'b0; v_i = 1'b0; ready_and_i = 1'b1;
      pc_i = '0; eff_addr_i = '0;
      repeat (3) @(posedge clk);
      #1 reset_i = 1'b0;
      @(negedge clk);
      chk("rst_v_o", 64'(v_o), 64'd0);
      chk("rst_pc_o", 64'(pc_o), 64'd0);
      chk("rst_eff_addr_o", 64'(eff_addr_o), 64'd0);
      chk("rst_stride_o", 64'(stride_o), 64'd0);
      chk("rst_loop_counter_o", 64'(loop_counter_o), 64'd0);

      // Steady positive stride: request appears the cycle after the third load.
      load(pc_a, 39'h2000);
      load(pc_a, 39'h2010);
      expect_req(pc_a, 39'h2020, 8'h10);
      load(pc_a, 39'h2020);
      @(negedge clk);
      chk("steady_not_early", 64'(v_o), 64'd0);
      idle(1);
      @(negedge clk);
      chk("steady_v", 64'(v_o), 64'd1);
      idle(1);
      @(negedge clk);
      chk("steady_drained", 64'(v_o), 64'd0);

      // Negative stride ends in NOPRED (stride 0xF0); one match there only reaches TRANSIENT.
      load(pc_b, 39'h3000);
      load(pc_b, 39'h2FF0);
      load(pc_b, 39'h2FE0);
      load(pc_b, 39'h2FD0);
      load(pc_b, 39'h30C0);
      idle(2);
      @(negedge clk);
      chk("neg_no_req", 64'(v_o), 64'd0);
      expect_req(pc_b, 39'h31B0, 8'hF0);
      load(pc_b, 39'h31B0);
      idle(1);
      @(negedge clk);
      chk("nopred_recover_v", 64'(v_o), 64'd1);
      idle(1);

      // Backpressure: first request held, later triggers dropped, drain+load in one cycle.
      ready_and_i = 1'b0;
      load(pc_c, 39'h4000);
      load(pc_c, 39'h4008);
      expect_req(pc_c, 39'h4010, 8'h08);
      load(pc_c, 39'h4010);
      load(pc_c, 39'h4018);
      load(pc_c, 39'h4020);
      idle(2);
      @(negedge clk);
      chk("bp_hold_v", 64'(v_o), 64'd1);
      expect_req(pc_c, 39'h4028, 8'h08);
      load(pc_c, 39'h4028);
      ready_and_i = 1'b1;
      idle(1);
      @(negedge clk);
      chk("bp_reload_v", 64'(v_o), 64'd1);
      idle(1);
      @(negedge clk);
      chk("bp_drained", 64'(v_o), 64'd0);

      // Aliasing PCs on one index keep reallocating; a shared entry would see stride 0x10.
      load(pc_d, 39'h5000);
      load(pc_e, 39'h5010);
      load(pc_d, 39'h5020);
      load(pc_e, 39'h5030);
      load(pc_d, 39'h5040);
      load(pc_e, 39'h5050);
      idle(2);
      @(negedge clk);
      chk("alias_no_req", 64'(v_o), 64'd0);

      // Flush wins over a same-cycle update; following accesses start from allocation.
      load(pc_f, 39'h7000);
      flush_load(pc_f, 39'h7020);
      load(pc_f, 39'h7040);
      load(pc_f, 39'h7060);
      idle(2);
      @(negedge clk);
      chk("flush_no_req", 64'(v_o), 64'd0);

      // Flush leaves a pending request alone.
      ready_and_i = 1'b0;
      load(pc_g, 39'h8000);
      load(pc_g, 39'h8004);
      expect_req(pc_g, 39'h8008, 8'h04);
      load(pc_g, 39'h8008);
      idle(1);
      @(posedge clk); #1;
      v_i = 1'b0; flush_i = 1'b1;
      idle(1);
      @(negedge clk);
      chk("flush_keeps_v", 64'(v_o), 64'd1);
      load(pc_g, 39'h800C);
      ready_and_i = 1'b1;
      idle(2);
      @(negedge clk);
      chk("flush_pending_drained", 64'(v_o), 64'd0);

      // Reset mid-handshake drops the request and empties the table.
      ready_and_i = 1'b0;
      load(pc_h, 39'h9000);
      load(pc_h, 39'h9001);
      expect_req(pc_h, 39'h9002, 8'h01);
      load(pc_h, 39'h9002);
      idle(2);
      @(negedge clk);
      chk("pre_reset_v", 64'(v_o), 64'd1);
      @(posedge clk); #1;
      reset_i = 1'b1; v_i = 1'b0;
      sb_q.delete();
      @(posedge clk); #1;
      reset_i = 1'b0;
      @(negedge clk);
      chk("reset_v_o", 64'(v_o), 64'd0);
      chk("reset_pc_o", 64'(pc_o), 64'd0);
      chk("reset_stride_o", 64'(stride_o), 64'd0);
      ready_and_i = 1'b1;
      load(pc_h, 39'h9003);
      load(pc_h, 39'h9004);
      idle(2);
      @(negedge clk);
      chk("post_reset_empty", 64'(v_o), 64'd0);

      idle(3);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bp_be_stride_detector.md
BP_BE_STRIDE_DETECTOR -- requirements
Module: bp_be_stride_detector

Interface
REQ-001 The block SHALL take parameter bp_params_p (default e_bp_default_cfg), which supplies vaddr_width_p.
REQ-002 The block SHALL take parameter rpt_entries_p (default 16; power of 2): number of reference-prediction-table (RPT) entries.
REQ-003 The block SHALL take parameter tag_width_p (default 10): width of the partial PC tag.
REQ-004 The block SHALL take parameter stride_width_p (default 8): unsigned stride width.
REQ-005 The block SHALL take parameter loop_range_p (default 8): width of the prefetch count.
REQ-006 The block SHALL take parameter prefetch_degree_p (default 4): count emitted per request.
REQ-007 The block SHALL have clk_i, input, 1 bit: the single clock.
REQ-008 The block SHALL have reset_i, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have flush_i, input, 1 bit: invalidate all RPT entries.
REQ-010 The block SHALL have v_i, input, 1 bit: a committed load is observed this cycle.
REQ-011 The block SHALL have pc_i, input, vaddr_width_p bits: PC of that load.
REQ-012 The block SHALL have eff_addr_i, input, vaddr_width_p bits: effective address of that load.
REQ-013 The block SHALL have v_o, output, 1 bit: a prefetch request is valid.
REQ-014 The block SHALL have ready_and_i, input, 1 bit: the downstream prefetch generator accepts the request.
REQ-015 The block SHALL have pc_o, output, vaddr_width_p bits: PC of the request.
REQ-016 The block SHALL have eff_addr_o, output, vaddr_width_p bits: base address of the request.
REQ-017 The block SHALL have stride_o, output, stride_width_p bits: stride of the request.
REQ-018 The block SHALL have loop_counter_o, output, loop_range_p bits: prefetch count of the request.

Function
REQ-019 Index and tag: index = pc_i[2 +: log2(rpt_entries_p)]; tag = the next tag_width_p PC bits above the index.
REQ-020 Entry contents: valid, tag, last_addr (vaddr_width_p), stride (stride_width_p), and state in {INIT, TRANSIENT, STEADY, NOPRED}.
REQ-021 Miss (v_i, entry invalid or tag mismatch): allocate valid=1, new tag, last_addr=eff_addr_i, stride=0, state INIT; no request.
REQ-022 Hit delta: d = eff_addr_i - last_addr, computed modulo 2^vaddr_width_p.
REQ-023 Hit match: match = (d == zero-extended entry stride) and d in range 1..2^stride_width_p-1.
REQ-024 Hit, last_addr update: on every hit, last_addr <= eff_addr_i.
REQ-025 INIT transitions: match -> STEADY; mismatch -> TRANSIENT, stride <= d[stride_width_p-1:0].
REQ-026 TRANSIENT transitions: match -> STEADY; mismatch -> NOPRED, stride <= d truncated.
REQ-027 STEADY transitions: match -> STEADY; mismatch -> INIT, stride unchanged.
REQ-028 NOPRED transitions: match -> TRANSIENT; mismatch -> NOPRED, stride <= d truncated.
REQ-029 Zero or out-of-range deltas SHALL never match, so strides of 0 and negative strides never issue.
REQ-030 Issue trigger: a hit with match whose next state is STEADY.
REQ-031 On a trigger, the output register SHALL load on the same clock edge: pc_o=pc_i, eff_addr_o=eff_addr_i, stride_o=entry stride, loop_counter_o=prefetch_degree_p.
REQ-032 Output latency: v_o SHALL assert the cycle after the triggering v_i.
REQ-033 Handshake: v_o/ready_and_i is valid-ready; v_o SHALL stay high and all outputs stable until v_o & ready_and_i.
REQ-034 Full output register: the register SHALL load when empty or when it drains in the same cycle (v_o & ready_and_i).
REQ-035 Dropped trigger: a trigger with the output register full and not draining SHALL be dropped; the table update still occurs.
REQ-036 Flush: flush_i SHALL clear all valid bits on the next edge and has priority over a simultaneous v_i update.
REQ-037 Flush and pending output: flush_i SHALL NOT cancel a pending v_o.
REQ-038 RPT timing: table read is combinational and the update is registered, so back-to-back loads to the same entry see the prior update.

Reset
REQ-039 reset_i SHALL clear all entry valid bits and v_o to 0 on the next edge, including mid-handshake.
REQ-040 Out of reset, pc_o, eff_addr_o, stride_o and loop_counter_o SHALL be 0.
REQ-041 Entry payloads other than valid need no reset.

Structure
REQ-042 bp_be_pkg SHALL hold the enum bp_be_rpt_state_e (INIT, TRANSIENT, STEADY, NOPRED).
REQ-043 bp_be_defines SHALL hold an entry-struct declare macro parameterised by vaddr, tag and stride widths.
REQ-044 The block SHALL use one sub-module, bp_be_rpt_update: combinational next-entry and trigger computation from {entry, pc, eff_addr}.
REQ-045 Table storage SHALL be flops in the top module.

Verification
REQ-046 Steady stride: PC 0x80001000 loads 0x2000, 0x2010, 0x2020 with ready_and_i=1 -> one request the cycle after the third load: eff_addr_o=0x2020, stride_o=0x10, loop_counter_o=4.
REQ-047 Negative stride: same PC, addresses 0x3000, 0x2FF0, 0x2FE0, 0x2FD0 -> v_o never asserts; entry ends in NOPRED.
REQ-048 Backpressure: steady stream with ready_and_i=0 for 5 cycles -> v_o held with outputs stable; later triggers dropped; first request transfers when ready_and_i rises.
REQ-049 Alias: two PCs share an index with different tags -> each access reallocates in INIT; no request issues.
REQ-050 Flush: flush_i asserted with v_i in the same cycle -> entry invalid afterwards; the next access to that PC allocates and does not issue.
REQ-051 Reset: reset_i asserted while v_o=1 -> v_o=0 the next cycle; the table is empty.
